// File: rtl/prog_clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Optional feature macro: PROG_CLOCK_DIVIDER_SYNC_EN (adds a global sync input on the top).
package prog_clock_divider_pkg;

  // Divisor loaded into every channel on reset unless overridden.
  localparam int unsigned DefaultDiv = 50_000_000;

  // Largest supported channel count.
  localparam int unsigned MaxNumCh = 16;

  // Width of the channel-select field; at least one bit even for a single channel.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and pending divisor, div_clk toggle and tick pulse.
// A pending divisor is swapped in only at a wrap so no half-period is ever truncated.
module clkdiv_channel #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             pending_o,
  output logic             div_clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Next-state: sync beats wrap; a disabled channel loads a pending divisor right away.
  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    div_clk_d  = div_clk_q;
    tick_d     = 1'b0;
    // >= rather than == keeps the counter bounded by D-1 even if state were ever corrupted.
    wrap       = (act_div_q != '0) && (cnt_q >= act_div_q - WIDTH'(1));

    if (sync_i) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      if (pend_q) begin
        act_div_d = pend_div_q;
        pend_d    = 1'b0;
      end
    end else if (act_div_q == '0) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      if (pend_q) begin
        act_div_d = pend_div_q;
        pend_d    = 1'b0;
      end
    end else if (wrap) begin
      cnt_d = '0;
      if (pend_q) begin
        act_div_d = pend_div_q;
        pend_d    = 1'b0;
      end
      if (pend_q && (pend_div_q == '0)) begin
        // Switching to disabled: park the output low instead of toggling.
        div_clk_d = 1'b0;
      end else begin
        div_clk_d = ~div_clk_q;
        tick_d    = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    // Accept only happens while nothing is pending, so it never races the load above.
    if (we_i) begin
      pend_div_d = div_i;
      pend_d     = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      act_div_q  <= WIDTH'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      div_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      div_clk_q  <= div_clk_d;
      tick_q     <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign div_clk_o = div_clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: cfg decode, cfg_ready mux and channel array.
// Optional feature macro: PROG_CLOCK_DIVIDER_SYNC_EN adds input `sync`, which realigns
// every channel to phase zero on the following cycle.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = DefaultDiv,
  localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);

  if ((NUM_CH < 1) || (NUM_CH > MaxNumCh)) begin : g_num_ch_check
    $error("prog_clock_divider: NUM_CH out of range");
  end

  logic [NUM_CH-1:0] cfg_we;
  logic              sync_int;

`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  assign sync_int = sync;
`else
  assign sync_int = 1'b0;
`endif

  // Channel select: out-of-range indices read as ready and write nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    cfg_we    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~cfg_pending[i];
        cfg_we[i] = cfg_valid & ~cfg_pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .sync_i    (sync_int),
      .we_i      (cfg_we[g]),
      .div_i     (cfg_div),
      .pending_o (cfg_pending[g]),
      .div_clk_o (div_clk[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider (NUM_CH=2, WIDTH=8, DEFAULT_DIV=3).
// The reference model describes each channel as a segment (start edge, divisor, start level)
// and derives div_clk/tick by arithmetic on the edge count.
module tb_prog_clock_divider;

  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned WIDTH       = 8;
  localparam int unsigned DEFAULT_DIV = 3;
  localparam int unsigned CH_W        = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [WIDTH-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] cfg_pending;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  logic              sync_r = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_clock_divider #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
    .sync        (sync_r),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_pending (cfg_pending),
    .div_clk     (div_clk),
    .tick        (tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;

  // Reference model state per channel.
  int seg_t0   [NUM_CH];
  int seg_d    [NUM_CH];
  bit seg_base [NUM_CH];
  bit seg_tick0[NUM_CH];
  bit m_pend   [NUM_CH];
  int m_pv     [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  function automatic bit exp_level(input int i);
    int k;
    if (seg_d[i] == 0) return 1'b0;
    k = n - seg_t0[i];
    return seg_base[i] ^ bit'((k / seg_d[i]) % 2);
  endfunction

  function automatic bit exp_tick(input int i);
    int k;
    if (seg_d[i] == 0) return 1'b0;
    k = n - seg_t0[i];
    if (k == 0) return seg_tick0[i];
    return (k % seg_d[i]) == 0;
  endfunction

  task automatic new_seg(input int i, input int d, input bit base, input bit tk);
    seg_t0[i]    = n;
    seg_d[i]     = d;
    seg_base[i]  = base;
    seg_tick0[i] = tk;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      new_seg(i, DEFAULT_DIV, 1'b0, 1'b0);
      m_pend[i] = 1'b0;
      m_pv[i]   = 0;
    end
  endtask

  // Apply one rising edge (edge index n already advanced) to the model.
  task automatic model_edge(input bit v, input int ch, input int d, input bit s);
    for (int i = 0; i < NUM_CH; i++) begin
      bit accept;
      int k;
      accept = v && (ch == i) && !m_pend[i];
      k = n - seg_t0[i];
      if (s) begin
        if (m_pend[i]) begin
          new_seg(i, m_pv[i], 1'b0, 1'b0);
          m_pend[i] = 1'b0;
        end else begin
          new_seg(i, seg_d[i], 1'b0, 1'b0);
        end
      end else if (m_pend[i]) begin
        if (seg_d[i] == 0) begin
          new_seg(i, m_pv[i], 1'b0, 1'b0);
          m_pend[i] = 1'b0;
        end else if (k > 0 && (k % seg_d[i]) == 0) begin
          if (m_pv[i] == 0) new_seg(i, 0, 1'b0, 1'b0);
          else              new_seg(i, m_pv[i], exp_level(i), 1'b1);
          m_pend[i] = 1'b0;
        end
      end
      if (accept) begin
        m_pend[i] = 1'b1;
        m_pv[i]   = d;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
    int ci;
    bit e_rdy;
    for (int i = 0; i < NUM_CH; i++) begin
      e_clk[i]  = exp_level(i);
      e_tick[i] = exp_tick(i);
      e_pend[i] = m_pend[i];
    end
    ci = int'(cfg_ch);
    e_rdy = (ci < NUM_CH) ? !m_pend[ci] : 1'b1;
    check_eq("div_clk", 32'(div_clk), 32'(e_clk));
    check_eq("tick", 32'(tick), 32'(e_tick));
    check_eq("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
  endtask

  // One clock: inputs are already stable; sample #1 after the edge.
  task automatic cycle();
    bit v;
    int ch;
    int d;
    bit s;
    v  = cfg_valid;
    ch = int'(cfg_ch);
    d  = int'(cfg_div);
    s  = 1'b0;
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
    s  = sync_r;
`endif
    @(posedge clk);
    n++;
    model_edge(v, ch, d, s);
    #1;
    compare_outputs();
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) cycle();
  endtask

  // Write a divisor, first letting any model-pending update on that channel drain (bounded).
  task automatic write_cfg(input int ch, input int d);
    int guard;
    guard = 0;
    while (m_pend[ch] && guard < 600) begin
      cycle();
      guard++;
    end
    if (m_pend[ch]) check_eq("write_wait_timeout", 32'(1), 32'(0));
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = WIDTH'(d);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_div_clk", 32'(div_clk), 32'(0));
    check_eq("rst_tick", 32'(tick), 32'(0));
    check_eq("rst_pending", 32'(cfg_pending), 32'(0));
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_tick[NUM_CH];
    int gap_prev;

    // Power-on reset held over a few edges.
    repeat (3) @(posedge clk);
    #1;
    check_eq("por_div_clk", 32'(div_clk), 32'(0));
    check_eq("por_tick", 32'(tick), 32'(0));
    check_eq("por_pending", 32'(cfg_pending), 32'(0));
    check_eq("por_ready", 32'(cfg_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    model_reset();

    // Free run at the reset divisor; first tick lands on the 3rd edge.
    for (int i = 0; i < NUM_CH; i++) first_tick[i] = -1;
    for (int c = 0; c < 24; c++) begin
      cycle();
      for (int i = 0; i < NUM_CH; i++)
        if (first_tick[i] < 0 && tick[i]) first_tick[i] = n;
    end
    check_eq("first_tick_ch0", 32'(first_tick[0]), 32'(3));
    check_eq("first_tick_ch1", 32'(first_tick[1]), 32'(3));

    // Mid-period update on channel 0.
    cycle();
    write_cfg(0, 5);
    check_eq("ch0_pending_after_write", 32'(cfg_pending[0]), 32'(1));
    check_eq("ch0_ready_low", 32'(cfg_ready), 32'(0));
    run(40);

    // Disable channel 1, then re-enable with D=2.
    write_cfg(1, 0);
    run(10);
    check_eq("ch1_disabled_low", 32'(div_clk[1]), 32'(0));
    write_cfg(1, 2);
    run(20);

    // Largest divisor for an 8-bit counter.
    write_cfg(0, 255);
    while (m_pend[0]) cycle();
    gap_prev = n;
    for (int c = 0; c < 1100; c++) begin
      cycle();
      if (tick[0]) begin
        check_eq("d255_tick_gap", 32'(n - gap_prev), 32'(255));
        gap_prev = n;
      end
    end

    // Reset pulse with an update pending; pending value must never appear.
    write_cfg(1, 7);
    reset_pulse();
    run(30);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_div   = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 9));
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
      sync_r    = ($urandom_range(0, 63) == 0);
`endif
      cycle();
      if (c == 1500) reset_pulse();
    end
    cfg_valid = 1'b0;
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
    sync_r = 1'b0;

    // Phase-offset channels realigned by sync; an update in the sync cycle stays pending.
    write_cfg(0, 3);
    write_cfg(1, 4);
    while (m_pend[0] || m_pend[1]) cycle();
    run(7);
    sync_r = 1'b1;
    cycle();
    sync_r = 1'b0;
    check_eq("sync_div_clk_zero", 32'(div_clk), 32'(0));
    check_eq("sync_tick_zero", 32'(tick), 32'(0));
    run(48);
    run(2);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(0);
    cfg_div   = WIDTH'(6);
    sync_r    = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    sync_r    = 1'b0;
    check_eq("sync_keeps_new_pending", 32'(cfg_pending[0]), 32'(1));
    run(30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
